uart_tx: RTL and testbench

UART transmitter that serialises one byte per request onto the `tx` line using 8N1 framing: one start bit (0), eight data bits LSB first, and one stop bit (1). The baud rate matches the receiver at 2604 clocks per bit. It is the transmit-side counterpart of the UART receive path. It sits between the command/response logic, which presents bytes with a one-cycle `trmt` strobe, and the serial pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 89 ++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;
   localparam int BAUD_DIV_DEFAULT = 2604;
   localparam int FRAME_BITS       = 10;

   typedef enum logic {IDLE, TX} tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and pulses baud_tick on the terminal count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic baud_tick
);
   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign baud_tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = baud_tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per trmt strobe, LSB first, tx driven straight from a register.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   tx_state_t             state_q, state_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [3:0]            bit_q, bit_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  accept;
   logic                  baud_tick;

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk       (clk),
      .rst       (rst),
      .clr       (accept),
      .en        (state_q == TX),
      .baud_tick (baud_tick)
   );

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bit_d   = bit_q;
      busy_d  = busy_q;
      done_d  = done_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trmt) begin
               accept  = 1'b1;
               sr_d    = {1'b1, tx_data, 1'b0};
               bit_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = TX;
            end
         end
         TX: begin
            if (baud_tick) begin
               // Ones shift in behind the frame, so the register is all ones again once the stop bit ends.
               sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '1;
         bit_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bit_q   <= bit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // The idle shift register holds all ones, so its LSB is also the idle-high line level.
   assign tx      = sr_q[0];
   assign tx_busy = busy_q;
   assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three dividers (2604, 16, 4) checked cycle-by-cycle against a bit scoreboard.
module tb_uart_tx;
   logic       clk = 1'b0;
   logic       rst;
   logic       trmt;
   logic [7:0] tx_data;
   int         sel;
   int         bdiv;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       exp_q[$];

   logic trmt_a, tx_a, busy_a, done_a;
   logic trmt_b, tx_b, busy_b, done_b;
   logic trmt_c, tx_c, busy_c, done_c;
   logic tx_m, busy_m, done_m;

   always #5 clk = ~clk;

   assign trmt_a = trmt && (sel == 0);
   assign trmt_b = trmt && (sel == 1);
   assign trmt_c = trmt && (sel == 2);

   uart_tx #(.BAUD_DIV(2604)) u_a (.clk(clk), .rst(rst), .trmt(trmt_a), .tx_data(tx_data),
                                   .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));
   uart_tx #(.BAUD_DIV(16))   u_b (.clk(clk), .rst(rst), .trmt(trmt_b), .tx_data(tx_data),
                                   .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));
   uart_tx #(.BAUD_DIV(4))    u_c (.clk(clk), .rst(rst), .trmt(trmt_c), .tx_data(tx_data),
                                   .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

   always_comb begin
      case (sel)
         0:       {tx_m, busy_m, done_m} = {tx_a, busy_a, done_a};
         1:       {tx_m, busy_m, done_m} = {tx_b, busy_b, done_b};
         default: {tx_m, busy_m, done_m} = {tx_c, busy_c, done_c};
      endcase
   end

   task automatic push_frame(input logic [7:0] b);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(1'b1);
   endtask

   // Strobe trmt for one edge (edge N); returns 1 time unit after edge N.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      trmt    = 1'b1;
      tx_data = b;
      push_frame(b);
      @(posedge clk);
      #1 trmt = 1'b0;
   endtask

   // Checks every cycle of one frame; trmt is pulsed at cycle poke and held from cycle tail to frame end.
   task automatic check_frame(input string name, input int poke, input int tail,
                              input bit chain, input logic [7:0] nxt);
      int   busy_cnt;
      int   j;
      logic e;
      logic got;
      bit   bad;
      busy_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty at bit %0d", name, k);
            return;
         end
         e   = exp_q.pop_front();
         bad = 1'b0;
         got = e;
         for (int c = 0; c < bdiv; c++) begin
            @(negedge clk);
            j = k * bdiv + c + 1;
            if (tx_m !== e && !bad) begin bad = 1'b1; got = tx_m; end
            if (busy_m === 1'b1) busy_cnt++;
            if (j == 1) begin
               n_tests++;
               if (done_m !== 1'b0 || busy_m !== 1'b1) begin
                  n_fail++;
                  $display("FAIL %s accept: busy=%b done=%b, expected busy=1 done=0", name, busy_m, done_m);
               end
            end
            trmt    = (j == poke) || (j >= tail);
            tx_data = trmt ? 8'hFF : 8'($urandom);
         end
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s bit %0d: tx=%b, expected %b", name, k, got, e);
         end
      end
      @(negedge clk);
      trmt = 1'b0;
      n_tests++;
      if (busy_cnt != 10 * bdiv) begin
         n_fail++;
         $display("FAIL %s busy length: %0d cycles, expected %0d", name, busy_cnt, 10 * bdiv);
      end
      n_tests++;
      if (busy_m !== 1'b0 || done_m !== 1'b1 || tx_m !== 1'b1) begin
         n_fail++;
         $display("FAIL %s frame end: tx=%b busy=%b done=%b, expected 1 0 1", name, tx_m, busy_m, done_m);
      end
      if (chain) begin
         trmt    = 1'b1;
         tx_data = nxt;
         push_frame(nxt);
         @(posedge clk);
         #1 trmt = 1'b0;
      end
   endtask

   task automatic check_idle(input string name, input int cycles);
      bit   bad;
      logic t, b;
      bad = 1'b0; t = 1'b1; b = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if ((tx_m !== 1'b1 || busy_m !== 1'b0) && !bad) begin bad = 1'b1; t = tx_m; b = busy_m; end
      end
      n_tests++;
      if (bad || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s idle: tx=%b busy=%b pending=%0d, expected tx=1 busy=0 pending=0",
                  name, t, b, exp_q.size());
      end
   endtask

   task automatic test_reset();
      sel = 0; bdiv = 2604;
      rst = 1'b1; trmt = 1'b1; tx_data = 8'hA5;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cycle %0d: tx=%b busy=%b done=%b, expected 1 0 0", i, tx_m, busy_m, done_m);
         end
      end
      @(negedge clk);
      rst = 1'b0; trmt = 1'b0;
      check_idle("reset", 20);
   endtask

   task automatic test_single_byte();
      sel = 0; bdiv = 2604;
      send(8'hA5);
      check_frame("single_A5", -1, 1 << 30, 1'b0, 8'h00);
      check_idle("single_A5", 5);
   endtask

   task automatic test_busy_latch();
      sel = 1; bdiv = 16;
      send(8'h3C);
      check_frame("busy_3C", 5 * bdiv + 3, 10 * bdiv - 1, 1'b0, 8'h00);
      check_idle("busy_no_second", 3 * bdiv);
   endtask

   task automatic test_back_to_back();
      sel = 1; bdiv = 16;
      send(8'h00);
      check_frame("b2b_00", -1, 1 << 30, 1'b1, 8'hFF);
      check_frame("b2b_FF", -1, 1 << 30, 1'b0, 8'h00);
      check_idle("b2b", 5);
   endtask

   task automatic test_reset_midframe();
      sel = 1; bdiv = 16;
      send(8'h5A);
      repeat (4 * bdiv + bdiv / 2) @(negedge clk);
      n_tests++;
      if (tx_m !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe data bit 3: tx=%b, expected 1", tx_m);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe reset: tx=%b busy=%b done=%b, expected 1 0 0", tx_m, busy_m, done_m);
      end
      rst = 1'b0;
      exp_q.delete();
      check_idle("after_reset", 4);
      send(8'h81);
      check_frame("post_reset_81", -1, 1 << 30, 1'b0, 8'h00);
      check_idle("post_reset_81", 5);
   endtask

   task automatic test_small_div();
      sel = 2; bdiv = 4;
      send(8'h96);
      check_frame("div4_96", -1, 1 << 30, 1'b0, 8'h00);
      check_idle("div4", 8);
   endtask

   initial begin
      sel = 0; bdiv = 2604; rst = 1'b1; trmt = 1'b0; tx_data = 8'h00;
      test_reset();
      test_single_byte();
      test_busy_latch();
      test_back_to_back();
      test_reset_midframe();
      test_small_div();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
